// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory arbiter: FSM state codes,
// requester indices and one-hot grant encodings.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  localparam int PORT_C = 0;
  localparam int PORT_L = 1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_C    = 2'b01;
  localparam logic [1:0] GNT_L    = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-input round-robin arbiter. The grant is combinational from req/mask and
// the last-grant flag; the flag only moves when the owner commits the grant.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       advance,
  output logic [1:0] grant
);

  logic       last_l;
  logic [1:0] elig;

  assign elig = req & ~mask;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant = GNT_NONE;
    if (elig == 2'b11)
      grant = last_l ? GNT_C : GNT_L;
    else if (elig[PORT_C])
      grant = GNT_C;
    else if (elig[PORT_L])
      grant = GNT_L;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_l <= 1'b1;
    else if (advance && (grant != GNT_NONE))
      last_l <= grant[PORT_L];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes CPU and loader accesses onto one synchronous memory port with a
// fixed read latency; every output is registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 20,
  parameter int LAT       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ready,
  output logic              c_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_hold,
  output logic              l_ready,
  output logic              l_err,
  output logic [DATA_W-1:0] rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        gnt
);

  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [1:0]        win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({l_req, c_req}),
    .mask    ({1'b0, l_hold}),
    .advance (state == IDLE),
    .grant   (win)
  );

  assign sel_we    = win[PORT_L] ? l_we    : c_we;
  assign sel_addr  = win[PORT_L] ? l_addr  : c_addr;
  assign sel_wdata = win[PORT_L] ? l_wdata : c_wdata;
  assign in_range  = {1'b0, sel_addr} < DEPTH;

  // m_addr/m_wdata double as the latched request registers, so they stay
  // stable for the whole access regardless of what the requester does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= GNT_NONE;
      cnt     <= '0;
      we_q    <= 1'b0;
      c_ready <= 1'b0;
      c_err   <= 1'b0;
      l_ready <= 1'b0;
      l_err   <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      rdata   <= '0;
    end else begin
      c_ready <= 1'b0;
      c_err   <= 1'b0;
      l_ready <= 1'b0;
      l_err   <= 1'b0;
      m_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (win != GNT_NONE) begin
            gnt     <= win;
            we_q    <= sel_we;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            if (in_range) begin
              state <= ACCESS;
              m_en  <= 1'b1;
              m_we  <= sel_we;
              cnt   <= CNT_W'(LAT - 1);
            end else begin
              state <= RESP;
              rdata <= '0;
              c_err <= win[PORT_C];
              l_err <= win[PORT_L];
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state   <= RESP;
            m_en    <= 1'b0;
            c_ready <= gnt[PORT_C];
            l_ready <= gnt[PORT_L];
            if (!we_q)
              rdata <= m_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          gnt   <= GNT_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single shared 16-bit instruction/data memory of the multicycle processor. It serializes accesses from two requesters onto one synchronous memory port with a configurable read latency: port C is the CPU control/datapath and port L is the program loader/debug port. Each requester sees a req/ready handshake, so the CPU control FSM can stall on memory waits. The block also rejects out-of-range addresses.

## Interface
Parameters:
- DATA_W, 16, data width
- ADDR_W, 16, address width
- MEM_DEPTH, 20, number of valid words; addresses ≥ MEM_DEPTH are errors
- LAT, 1, memory read latency in cycles (legal 1..8)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- c_req  in  1  CPU request; held high until c_ready or c_err
- c_we  in  1  CPU write enable (1 = write, 0 = read)
- c_addr  in  ADDR_W  CPU address
- c_wdata  in  DATA_W  CPU write data
- c_ready  out  1  one-cycle pulse: CPU access complete
- c_err  out  1  one-cycle pulse: CPU address out of range
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as the CPU port
- l_hold  in  1  loader exclusive mode; while high, the CPU is never granted
- l_ready, l_err  out  1  loader completion / error pulses
- rdata  out  DATA_W  read data, valid in the ready cycle of the granted port
- m_en  out  1  memory enable
- m_we  out  1  memory write strobe
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid LAT cycles after the first m_en cycle
- gnt  out  2  current owner, one-hot {L, C}; 00 when idle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Eligible requesters: c_req (only when l_hold = 0) and l_req.
  - One eligible requester: it wins. Both eligible: round-robin, the winner is the port not granted last.
  - On the winning edge the block latches we, addr and wdata into internal registers, sets gnt, and updates last_grant.
- Address check (on the winner):
  - addr < MEM_DEPTH: go to ACCESS.
  - addr ≥ MEM_DEPTH: go directly to RESP with the error flag set. No memory cycle is issued.
- ACCESS lasts exactly LAT cycles:
  - m_en = 1, with m_addr and m_wdata driven from the latched registers throughout.
  - m_we = 1 in the first ACCESS cycle only.
  - A down-counter of width clog2(LAT+1) loads LAT-1 on entry.
  - On the last ACCESS edge, rdata <= m_rdata for reads; for writes rdata is unchanged.
- RESP lasts one cycle:
  - The owner's ready pulses, or its err pulses on an address error; on error rdata = 0.
  - Then go to IDLE and set gnt = 00.
- RESP always returns to IDLE. A req still high in RESP is not counted as a new request; it is re-evaluated in IDLE.
- Requester inputs are ignored outside IDLE. Changing addr or wdata mid-transaction has no effect.
- l_hold rising while a CPU transaction is in flight does not abort it; the CPU transaction completes normally.
- Reset values: state IDLE, gnt 00, all ready/err 0, m_en 0, m_we 0, m_addr 0, m_wdata 0, rdata 0, last_grant = L (so the CPU wins the first tie).

## Timing
- Edge 0: request sampled in IDLE.
- Cycles 1..LAT: ACCESS.
- Cycle LAT+1: ready.
- Minimum request-to-request period per port is LAT+2 cycles.
- Error latency: err pulses in cycle 1.
- Asynchronous reset mid-ACCESS:
  - m_en and m_we drop immediately, no ready or err is issued, and the FSM returns to IDLE.
  - A write is committed only if its first ACCESS edge has occurred.
- Simultaneous requests under round-robin are served alternately. Worst-case CPU wait with l_hold = 0 is one loader transaction.
- All outputs are registered; there is no combinational path from req to m_*.

## Structure
- Package mem_arb_pkg: the state enum (IDLE, ACCESS, RESP), port index constants PORT_C = 0 and PORT_L = 1, and the one-hot gnt encodings.
- Sub-module rr_arbiter2: 2-input round-robin arbiter with last_grant state and a mask input (for l_hold). It is instantiated once.
- Top level: FSM, latency counter, address check and output registers.

## Test plan
- CPU read, LAT = 1, c_addr = 5, mem[5] = 16'h1234: m_en high in cycle 1, c_ready and rdata = 16'h1234 in cycle 2, gnt = 01 during the transaction.
- Loader write, LAT = 3, l_addr = 7, l_wdata = 16'hBEEF: m_we high in cycle 1 only, m_en high in cycles 1..3, l_ready in cycle 4, mem[7] = 16'hBEEF afterwards.
- c_req and l_req asserted together at reset exit, requests held: grants go C, L, C, L; each port receives a ready every 2·(LAT+2) cycles.
- l_hold = 1 with both requests held: only L is granted and c_ready never fires. Dropping l_hold lets C win the next IDLE.
- c_addr = 20 (MEM_DEPTH = 20): m_en never rises, c_err pulses in cycle 1, rdata = 0, no c_ready.
- Reset asserted in the second ACCESS cycle with LAT = 3: m_en = 0 immediately, no ready, gnt = 00. The next request then completes normally.
